uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles allowed from tx_start to tx_finish rising.
REQ-003 clk  input  1  the only clock; all flops update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester level request; held high until the matching ack.
REQ-006 req_data  input  8*NUM_REQ  byte of requester k on bits [8k+7:8k].
REQ-007 ack  output  NUM_REQ  one-hot, one-cycle pulse when requester's byte has finished.
REQ-008 grant  output  NUM_REQ  one-hot owner of the sender, held from START through ACK.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 tx_start  output  1  one-cycle start pulse to the UART sender.
REQ-011 tx_data  output  8  byte to the sender, registered and stable from START until the next arbitration.
REQ-012 tx_finish  input  1  sender's finish flag: low while framing, high once stop bits are sent.
REQ-013 tx_error  output  1  sticky timeout flag.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE, ACK and GAP, encoded in 3 bits.
REQ-015 IDLE with any req bit high: the FSM SHALL select the winner round-robin, searching from index ptr upward with wrap to 0.
REQ-016 On that same edge the FSM SHALL register the winner into grant and win_idx and its byte into tx_data, then go to START.
REQ-017 IDLE with req all zero: the FSM SHALL stay in IDLE, with grant, tx_start and ack all 0.
REQ-018 START: tx_start=1 for exactly this cycle; the FSM SHALL clear the timeout counter and go to WAIT_BUSY.
REQ-019 WAIT_BUSY: the FSM SHALL advance to WAIT_DONE on the first cycle tx_finish==0; otherwise it stays.
REQ-020 WAIT_DONE: the FSM SHALL advance to ACK on the first cycle tx_finish==1; otherwise it stays.
REQ-021 In WAIT_BUSY and WAIT_DONE the timeout counter SHALL increment each cycle, saturating.
REQ-022 When the counter reaches TIMEOUT in either wait state, the FSM SHALL set tx_error=1 and go to ACK.
REQ-023 ACK: ack = grant for exactly this cycle; ptr SHALL become (win_idx+1) mod NUM_REQ; the FSM goes to GAP.
REQ-024 GAP: exactly one idle cycle with tx_start=0, so the sender has returned to idle; grant SHALL clear to 0; the FSM goes to IDLE.
REQ-025 Minimum spacing between consecutive tx_start pulses SHALL be 6 cycles plus the sender frame time.
REQ-026 Requests SHALL NOT be re-arbitrated while busy=1.
REQ-027 A req drop mid-transfer SHALL be ignored: the byte completes and ack still pulses.
REQ-028 New req bits asserted while busy SHALL wait for the next IDLE.
REQ-029 A requester whose req stays high after its ack SHALL be treated as a new request, subject to round-robin.
REQ-030 req_data changes after latching SHALL NOT affect tx_data.
REQ-031 Worst-case wait for any requester SHALL be NUM_REQ-1 other transfers.
REQ-032 ptr SHALL be a $clog2(NUM_REQ)-bit register.
REQ-033 The wrap search SHALL be combinational and complete in the single IDLE cycle.
REQ-034 tx_error SHALL clear only on reset; a timeout SHALL still ack the requester so that no requester deadlocks.

Reset
REQ-035 With reset high at a clock edge: state=IDLE, ptr=0, grant=0, ack=0, tx_start=0, tx_data=8'h00, busy=0, tx_error=0, counter=0.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer without an ack.
REQ-037 Reset SHALL take priority over all other events at the same edge.
REQ-038 No output SHALL be X after the first reset edge.

Verification
REQ-039 Single request: req=4'b0100, req_data[23:16]=8'hA5 -> grant=4'b0100 and tx_data=8'hA5 one cycle later; tx_start pulses once; ack=4'b0100 pulses one cycle after tx_finish rises.
REQ-040 All-request fairness: req=4'b1111 held, four transfers -> grant order 0,1,2,3, then 0 again; exactly one ack per transfer.
REQ-041 Pointer wrap: ptr=3 after serving requester 2, then req=4'b1001 -> requester 3 is granted first, then requester 0.
REQ-042 Timeout: the sender model never drops tx_finish -> after TIMEOUT cycles tx_error=1, ack pulses, and the next request is served normally with tx_error still 1.
REQ-043 Mid-transfer disturbance: req drops and req_data changes during WAIT_DONE -> the original byte is sent unchanged and ack still pulses.
REQ-044 Mid-transfer reset: reset asserted in WAIT_DONE -> all outputs match their reset values at the next edge and no ack is produced.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester's byte at a time to a UART sender.
// Handshake: req is a level held until its one-cycle ack; ack pulses whether the byte completed or timed out.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_finish,
  output logic                 tx_error,
  output logic [2:0]           dbgState
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    ACK       = 3'd4,
    GAP       = 3'd5
  } stateT;

  stateT         state;
  stateT         nextState;
  logic [PW-1:0] ptr;
  logic [PW-1:0] winIdx;
  logic [PW-1:0] pick;
  logic          found;
  logic [PW:0]   idx;
  logic [CW-1:0] cnt;
  logic          timedOut;
  logic          timeoutHit;

  // Search from ptr upward, wrapping to 0; first asserted req wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PW + 1)'(i);
      if (idx >= (PW + 1)'(NUM_REQ)) idx = idx - (PW + 1)'(NUM_REQ);
      if (!found && req[idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  assign timedOut = (cnt == CW'(TIMEOUT));
  // Normal progress wins over a timeout landing on the same cycle.
  assign timeoutHit = timedOut &&
                      (((state == WAIT_BUSY) && tx_finish) ||
                       ((state == WAIT_DONE) && !tx_finish));

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (found) nextState = START;
      START:     nextState = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_finish)     nextState = WAIT_DONE;
        else if (timedOut)  nextState = ACK;
      end
      WAIT_DONE: begin
        if (tx_finish)      nextState = ACK;
        else if (timedOut)  nextState = ACK;
      end
      ACK:       nextState = GAP;
      GAP:       nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      winIdx   <= '0;
      grant    <= '0;
      tx_data  <= 8'h00;
      cnt      <= '0;
      tx_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            winIdx  <= pick;
            tx_data <= req_data[{pick, 3'b000} +: 8];
          end
        end
        START: cnt <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          if (!timedOut)  cnt <= cnt + CW'(1);
          if (timeoutHit) tx_error <= 1'b1;
        end
        ACK: ptr <= (winIdx == PW'(NUM_REQ - 1)) ? '0 : winIdx + PW'(1);
        GAP: grant <= '0;
        default: ;
      endcase
    end
  end

  assign tx_start = (state == START);
  assign busy     = (state != IDLE);
  assign ack      = (state == ACK) ? grant : '0;
  assign dbgState = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random request masks,
// with expected {grant, byte} pairs queued at stimulus time and popped on each tx_start.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_finish;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_error;
  logic [2:0]  dbgState;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .ack(ack), .grant(grant), .busy(busy), .tx_start(tx_start),
    .tx_data(tx_data), .tx_finish(tx_finish), .tx_error(tx_error),
    .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  logic [11:0] exp_q[$];
  int          nChecks = 0;
  int          nPassed = 0;
  int          ackCount = 0;
  int          cycle = 0;
  int          lastStart = 0;
  logic        startSeen = 1'b0;
  logic [3:0]  expGrant = '0;
  logic [11:0] monE;
  logic        senderStuck = 1'b0;
  int          modelPtr;

  always @(posedge clk) cycle++;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPassed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // UART sender model: drops tx_finish shortly after tx_start, raises it after a frame.
  initial begin
    tx_finish = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !senderStuck) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tx_finish = 1'b0;
        repeat ($urandom_range(3, 8)) @(negedge clk);
        tx_finish = 1'b1;
      end
    end
  end

  // Scoreboard: each tx_start must match the oldest queued {grant, byte}.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start === 1'b1) begin
        checkEq("startQueued", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          monE = exp_q.pop_front();
          checkEq("grant", grant, monE[11:8]);
          checkEq("txData", tx_data, monE[7:0]);
          expGrant = monE[11:8];
        end
        if (startSeen) checkEq("startSpacing", 32'((cycle - lastStart) >= 6), 32'd1);
        startSeen = 1'b1;
        lastStart = cycle;
      end
      if (ack !== 4'b0000) begin
        ackCount++;
        checkEq("ackOwner", ack, expGrant);
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clk);
    #1;
    checkEq("rstState", dbgState, 3'd0);
    checkEq("rstGrant", grant, 4'b0000);
    checkEq("rstAck", ack, 4'b0000);
    checkEq("rstTxStart", tx_start, 1'b0);
    checkEq("rstTxData", tx_data, 8'h00);
    checkEq("rstBusy", busy, 1'b0);
    checkEq("rstTxError", tx_error, 1'b0);
    reset = 1'b0;
  endtask

  task automatic waitAcks(input int n, input logic [3:0] keep, input int budget);
    int base;
    base = ackCount;
    for (int c = 0; c < budget && (ackCount - base) < n; c++) begin
      @(negedge clk);
      #1;
      if (ack !== 4'b0000) req = req & (keep | ~ack);
    end
    checkEq("ackCount", ackCount - base, n);
  endtask

  task automatic waitState(input logic [2:0] st, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (dbgState == st) break;
    end
    checkEq("reachState", dbgState, st);
  endtask

  initial begin
    int base;
    int cnt;
    logic [3:0] m;

    doReset();

    // Single request from requester 2.
    base = ackCount;
    req_data[23:16] = 8'hA5;
    exp_q.push_back({4'b0100, 8'hA5});
    req = 4'b0100;
    @(negedge clk); #1;
    checkEq("singleGrant", grant, 4'b0100);
    checkEq("singleTxData", tx_data, 8'hA5);
    checkEq("singleTxStart", tx_start, 1'b1);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (dbgState == 3'd3 && tx_finish) break;
    end
    @(negedge clk); #1;
    checkEq("singleAck", ack, 4'b0100);
    req = '0;
    repeat (4) @(negedge clk);
    checkEq("singleAckOnce", ackCount - base, 1);

    // Fairness with all four requests held.
    doReset();
    req_data = 32'h44332211;
    for (int k = 0; k < 4; k++) exp_q.push_back({4'(1) << k, 8'(8'h11 * (k + 1))});
    exp_q.push_back({4'b0001, 8'h11});
    req = 4'b1111;
    waitAcks(5, 4'b1111, 300);
    req = '0;
    checkEq("fairQueueEmpty", exp_q.size(), 0);

    // Pointer wrap: serve requester 2, then 3 before 0.
    doReset();
    req_data[23:16] = 8'h5A;
    exp_q.push_back({4'b0100, 8'h5A});
    req = 4'b0100;
    waitAcks(1, 4'b0000, 100);
    req_data = 32'h9C00003E;
    exp_q.push_back({4'b1000, 8'h9C});
    exp_q.push_back({4'b0001, 8'h3E});
    req = 4'b1001;
    waitAcks(2, 4'b0000, 100);
    checkEq("wrapQueueEmpty", exp_q.size(), 0);

    // Timeout: sender never drops tx_finish.
    senderStuck = 1'b1;
    req_data[15:8] = 8'h77;
    exp_q.push_back({4'b0010, 8'h77});
    checkEq("errBefore", tx_error, 1'b0);
    req = 4'b0010;
    waitAcks(1, 4'b0000, 400);
    checkEq("errAfterTimeout", tx_error, 1'b1);
    senderStuck = 1'b0;
    req_data[23:16] = 8'h88;
    exp_q.push_back({4'b0100, 8'h88});
    req = 4'b0100;
    waitAcks(1, 4'b0000, 100);
    checkEq("errSticky", tx_error, 1'b1);

    // Mid-transfer req drop and data change.
    doReset();
    req_data[7:0] = 8'hAA;
    exp_q.push_back({4'b0001, 8'hAA});
    req = 4'b0001;
    waitState(3'd3, 60);
    req = '0;
    req_data[7:0] = 8'h55;
    @(negedge clk); #1;
    checkEq("txDataHeld", tx_data, 8'hAA);
    waitAcks(1, 4'b0000, 60);
    checkEq("txDataAfterAck", tx_data, 8'hAA);

    // Reset in WAIT_DONE aborts without an ack.
    req_data[15:8] = 8'h3C;
    exp_q.push_back({4'b0010, 8'h3C});
    req = 4'b0010;
    waitState(3'd3, 60);
    base = ackCount;
    reset = 1'b1;
    req = '0;
    @(negedge clk); #1;
    checkEq("abortState", dbgState, 3'd0);
    checkEq("abortGrant", grant, 4'b0000);
    checkEq("abortAck", ack, 4'b0000);
    checkEq("abortTxData", tx_data, 8'h00);
    checkEq("abortBusy", busy, 1'b0);
    checkEq("abortTxStart", tx_start, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    checkEq("abortNoAck", ackCount - base, 0);

    // Random request masks against a round-robin reference.
    modelPtr = 0;
    for (int r = 0; r < 6; r++) begin
      m = 4'($urandom_range(1, 15));
      req_data = $urandom;
      req = m;
      cnt = 0;
      while (m != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          int k;
          k = (modelPtr + i) % 4;
          if (m[k]) begin
            exp_q.push_back({4'(1) << k, req_data[8*k +: 8]});
            m[k] = 1'b0;
            modelPtr = (k + 1) % 4;
            cnt++;
            break;
          end
        end
      end
      waitAcks(cnt, 4'b0000, 400);
      checkEq("randQueueEmpty", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
